// File: rtl/dtm_pkg.sv
// Shared types and constants for the parametrised JTAG DTM: IR codes, DMI op/resp
// encodings, the DTMCS layout and the IEEE 1149.1 TAP state encoding.
package dtm_pkg;

   localparam logic [4:0] IR_IDCODE  = 5'h01;
   localparam logic [4:0] IR_DTMCS   = 5'h10;
   localparam logic [4:0] IR_DMI     = 5'h11;
   localparam logic [4:0] IR_BUSYCNT = 5'h12;
   localparam logic [4:0] IR_BYPASS  = 5'h1F;
   localparam logic [4:0] IR_CAPTURE = 5'b00101;

   localparam int unsigned DATA_W         = 32;
   localparam int unsigned RESP_W         = 34;
   localparam int unsigned BUSYCNT_W      = 16;
   localparam int unsigned DTMCS_RST_BIT  = 16;
   localparam int unsigned DTMCS_HRST_BIT = 17;

   typedef enum logic [1:0] {
      DTM_NOP,
      DTM_READ,
      DTM_WRITE,
      DTM_RSVD
   } dtm_op_e;

   typedef enum logic [1:0] {
      DTM_SUCCESS,
      DTM_RESP_RSVD,
      DTM_FAILED,
      DTM_BUSY
   } dtm_resp_e;

   typedef struct packed {
      logic [13:0] zero1;
      logic        dmihardreset;
      logic        dmireset;
      logic        zero0;
      logic [2:0]  idle;
      logic [1:0]  dmistat;
      logic [5:0]  abits;
      logic [3:0]  version;
   } dtmcs_t;

   typedef enum logic [3:0] {
      TAP_TLR,
      TAP_RTI,
      TAP_SEL_DR,
      TAP_CAP_DR,
      TAP_SHIFT_DR,
      TAP_EXIT1_DR,
      TAP_PAUSE_DR,
      TAP_EXIT2_DR,
      TAP_UPD_DR,
      TAP_SEL_IR,
      TAP_CAP_IR,
      TAP_SHIFT_IR,
      TAP_EXIT1_IR,
      TAP_PAUSE_IR,
      TAP_EXIT2_IR,
      TAP_UPD_IR
   } tap_state_e;

   typedef enum logic [2:0] {
      DR_BYPASS,
      DR_IDCODE,
      DR_DTMCS,
      DR_DMI,
      DR_BUSYCNT
   } dr_sel_e;

   typedef enum logic [1:0] {
      DMI_IDLE,
      DMI_REQ,
      DMI_WAIT_RESP
   } dmi_state_e;

   // IEEE 1149.1 TAP next-state table
   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      tap_state_e n;
      case (s)
         TAP_TLR:      n = tms ? TAP_TLR      : TAP_RTI;
         TAP_RTI:      n = tms ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_DR:   n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
         TAP_CAP_DR:   n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_SHIFT_DR: n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_EXIT1_DR: n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
         TAP_PAUSE_DR: n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
         TAP_EXIT2_DR: n = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
         TAP_UPD_DR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_IR:   n = tms ? TAP_TLR      : TAP_CAP_IR;
         TAP_CAP_IR:   n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_SHIFT_IR: n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_EXIT1_IR: n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
         TAP_PAUSE_IR: n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
         TAP_EXIT2_IR: n = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
         TAP_UPD_IR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
         default:      n = TAP_TLR;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/dmi_jtag_dtm_param_if.sv
// DMI request/response handshake between the DTM (master) and the Debug Module (slave).
interface dmi_jtag_dtm_param_if
   import dtm_pkg::*;
#(
   parameter int unsigned ABITS = 7
);

   logic [ABITS+33:0] dmi_req_o;
   logic              dmi_req_valid_o;
   logic              dmi_req_ready_i;
   logic [RESP_W-1:0] dmi_resp_i;
   logic              dmi_resp_valid_i;
   logic              dmi_resp_ready_o;

   modport master (
      output dmi_req_o,
      output dmi_req_valid_o,
      input  dmi_req_ready_i,
      input  dmi_resp_i,
      input  dmi_resp_valid_i,
      output dmi_resp_ready_o
   );

   modport slave (
      input  dmi_req_o,
      input  dmi_req_valid_o,
      output dmi_req_ready_i,
      output dmi_resp_i,
      output dmi_resp_valid_i,
      input  dmi_resp_ready_o
   );

endinterface

// File: rtl/dmi_jtag_tap_fsm.sv
// TAP controller, instruction register with DR-select decode, and the falling-edge
// td_o/tdo_oe_o output stage. Honours DTM_BUSY_COUNT_EN for the BUSYCNT IR code.
module dmi_jtag_tap_fsm
   import dtm_pkg::*;
#(
   parameter int unsigned IRLENGTH = 5
) (
   input  logic       tck_i,
   input  logic       trst_ni,
   input  logic       tms_i,
   input  logic       td_i,
   input  logic       dr_tdo,
   output tap_state_e tap_state,
   output dr_sel_e    dr_sel_c,
   output logic       tlr_enter_c,
   output logic       td_o,
   output logic       tdo_oe_o
);

   logic [IRLENGTH-1:0] ir_shift;
   logic [IRLENGTH-1:0] ir_q;

   assign tlr_enter_c = (tap_state != TAP_TLR) && (tap_next(tap_state, tms_i) == TAP_TLR);

   // TAP state plus IR capture/shift/update; Test-Logic-Reset forces IDCODE
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         tap_state <= TAP_TLR;
         ir_shift  <= '0;
         ir_q      <= IRLENGTH'(IR_IDCODE);
      end else begin
         tap_state <= tap_next(tap_state, tms_i);
         case (tap_state)
            TAP_TLR:      ir_q     <= IRLENGTH'(IR_IDCODE);
            TAP_CAP_IR:   ir_shift <= IRLENGTH'(IR_CAPTURE);
            TAP_SHIFT_IR: ir_shift <= {td_i, ir_shift[IRLENGTH-1:1]};
            TAP_UPD_IR:   ir_q     <= ir_shift;
            default:      ;
         endcase
      end
   end

   // Unknown codes fall through to BYPASS
   always_comb begin
      dr_sel_c = DR_BYPASS;
      if (ir_q == IRLENGTH'(IR_IDCODE)) begin
         dr_sel_c = DR_IDCODE;
      end else if (ir_q == IRLENGTH'(IR_DTMCS)) begin
         dr_sel_c = DR_DTMCS;
      end else if (ir_q == IRLENGTH'(IR_DMI)) begin
         dr_sel_c = DR_DMI;
      end else if (ir_q == IRLENGTH'(IR_BUSYCNT)) begin
`ifdef DTM_BUSY_COUNT_EN
         dr_sel_c = DR_BUSYCNT;
`else
         dr_sel_c = DR_BYPASS;
`endif
      end else if (ir_q == IRLENGTH'(IR_BYPASS)) begin
         dr_sel_c = DR_BYPASS;
      end
   end

   always_ff @(negedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         td_o     <= 1'b0;
         tdo_oe_o <= 1'b0;
      end else begin
         tdo_oe_o <= (tap_state == TAP_SHIFT_IR) || (tap_state == TAP_SHIFT_DR);
         if (tap_state == TAP_SHIFT_IR) begin
            td_o <= ir_shift[0];
         end else if (tap_state == TAP_SHIFT_DR) begin
            td_o <= dr_tdo;
         end else begin
            td_o <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/dmi_jtag_dtm_param.sv
// Parametrised RISC-V JTAG DTM: DR registers, sticky error model and DMI handshake FSM.
// Define DTM_BUSY_COUNT_EN to add the 16-bit BUSYCNT data register on IR 0x12.
module dmi_jtag_dtm_param
   import dtm_pkg::*;
#(
   parameter int unsigned ABITS       = 7,
   parameter int unsigned IRLENGTH    = 5,
   parameter logic [31:0] IDCODE      = 32'h0000_0DB3,
   parameter int unsigned IDLE_CYCLES = 1
) (
   input  logic                 tck_i,
   input  logic                 trst_ni,
   input  logic                 tms_i,
   input  logic                 td_i,
   output logic                 td_o,
   output logic                 tdo_oe_o,
   output logic                 dmi_clear_o,
   dmi_jtag_dtm_param_if.master dmi
);

   localparam int unsigned DMI_W = ABITS + 34;
   localparam int unsigned DR_W  = DMI_W;

   if (IDCODE[0] != 1'b1) begin : g_idcode_chk
      $error("IDCODE bit 0 must be 1");
   end
   if ((ABITS < 1) || (ABITS > 32)) begin : g_abits_chk
      $error("ABITS must be in 1..32");
   end
   if (IRLENGTH < 5) begin : g_irlen_chk
      $error("IRLENGTH must be at least 5");
   end
   if (IDLE_CYCLES > 7) begin : g_idle_chk
      $error("IDLE_CYCLES must be in 0..7");
   end

   tap_state_e       tap_state;
   dr_sel_e          dr_sel_c;
   logic             tlr_enter_c;
   logic [DR_W-1:0]  dr_q;
   logic [DR_W-1:0]  dr_capture_c;
   logic [DR_W-1:0]  dr_shift_c;
   logic [ABITS-1:0] last_addr_q;
   logic [31:0]      last_data_q;
   logic [1:0]       sticky_q;
   dmi_state_e       dmi_state_q;
   dtmcs_t           dtmcs_cap_c;

   dmi_jtag_tap_fsm #(
      .IRLENGTH (IRLENGTH)
   ) u_tap (
      .tck_i       (tck_i),
      .trst_ni     (trst_ni),
      .tms_i       (tms_i),
      .td_i        (td_i),
      .dr_tdo      (dr_q[0]),
      .tap_state   (tap_state),
      .dr_sel_c    (dr_sel_c),
      .tlr_enter_c (tlr_enter_c),
      .td_o        (td_o),
      .tdo_oe_o    (tdo_oe_o)
   );

   logic             capture_c;
   logic             shift_c;
   logic             update_c;
   logic             outstanding_c;
   logic [1:0]       dmi_status_c;
   dtm_op_e          upd_op_c;
   logic [ABITS-1:0] upd_addr_c;
   logic [31:0]      upd_data_c;
   logic             start_c;
   logic             busy_req_c;
   logic             resp_fire_c;
   dtm_resp_e        resp_code_c;
   logic             resp_failed_c;
   logic             resp_busy_c;
   logic             dmireset_c;
   logic             hardreset_c;
   logic             busy_set_c;

   assign capture_c     = (tap_state == TAP_CAP_DR);
   assign shift_c       = (tap_state == TAP_SHIFT_DR);
   assign update_c      = (tap_state == TAP_UPD_DR);
   assign outstanding_c = (dmi_state_q != DMI_IDLE);
   assign dmi_status_c  = (sticky_q != 2'd0) ? sticky_q : (outstanding_c ? 2'd3 : 2'd0);

   assign upd_op_c   = dtm_op_e'(dr_q[1:0]);
   assign upd_data_c = dr_q[33:2];
   assign upd_addr_c = dr_q[DMI_W-1:34];

   // A new op is only accepted when idle and error-free; a colliding scan raises busy
   assign start_c    = update_c && (dr_sel_c == DR_DMI) && (sticky_q == 2'd0) && !outstanding_c &&
                       ((upd_op_c == DTM_READ) || (upd_op_c == DTM_WRITE));
   assign busy_req_c = (dr_sel_c == DR_DMI) && (capture_c || update_c) &&
                       (sticky_q == 2'd0) && outstanding_c;

   assign resp_fire_c   = (dmi_state_q == DMI_WAIT_RESP) && dmi.dmi_resp_valid_i;
   assign resp_code_c   = dtm_resp_e'(dmi.dmi_resp_i[1:0]);
   assign resp_failed_c = resp_fire_c && (resp_code_c == DTM_FAILED);
   assign resp_busy_c   = resp_fire_c && (resp_code_c == DTM_BUSY);

   assign dmireset_c  = update_c && (dr_sel_c == DR_DTMCS) && dr_q[DTMCS_RST_BIT];
   assign hardreset_c = update_c && (dr_sel_c == DR_DTMCS) && dr_q[DTMCS_HRST_BIT];
   assign busy_set_c  = (sticky_q == 2'd0) && !resp_failed_c && (busy_req_c || resp_busy_c);

   always_comb begin
      dtmcs_cap_c         = '0;
      dtmcs_cap_c.version = 4'd1;
      dtmcs_cap_c.abits   = 6'(ABITS);
      dtmcs_cap_c.dmistat = sticky_q;
      dtmcs_cap_c.idle    = 3'(IDLE_CYCLES);
   end

`ifdef DTM_BUSY_COUNT_EN
   logic [BUSYCNT_W-1:0] busy_cnt_q;

   // Saturating count of busy events; a 1 in bit 0 on Update clears it
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         busy_cnt_q <= '0;
      end else if (update_c && (dr_sel_c == DR_BUSYCNT) && dr_q[0]) begin
         busy_cnt_q <= '0;
      end else if (busy_set_c && (busy_cnt_q != {BUSYCNT_W{1'b1}})) begin
         busy_cnt_q <= busy_cnt_q + BUSYCNT_W'(1);
      end
   end
`endif

   // Per-register capture value and LSB-first shift with the register's own length
   always_comb begin
      dr_capture_c = '0;
      dr_shift_c   = DR_W'(td_i);
      case (dr_sel_c)
         DR_IDCODE: begin
            dr_capture_c = DR_W'(IDCODE);
            dr_shift_c   = DR_W'({td_i, dr_q[31:1]});
         end
         DR_DTMCS: begin
            dr_capture_c = DR_W'(dtmcs_cap_c);
            dr_shift_c   = DR_W'({td_i, dr_q[31:1]});
         end
         DR_DMI: begin
            dr_capture_c = {last_addr_q, last_data_q, dmi_status_c};
            dr_shift_c   = {td_i, dr_q[DR_W-1:1]};
         end
`ifdef DTM_BUSY_COUNT_EN
         DR_BUSYCNT: begin
            dr_capture_c = DR_W'(busy_cnt_q);
            dr_shift_c   = DR_W'({td_i, dr_q[BUSYCNT_W-1:1]});
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         dr_q <= '0;
      end else if (capture_c) begin
         dr_q <= dr_capture_c;
      end else if (shift_c) begin
         dr_q <= dr_shift_c;
      end
   end

   // Failed always wins over busy; only the reset paths clear a sticky error
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         sticky_q <= 2'd0;
      end else if (dmireset_c || hardreset_c) begin
         sticky_q <= 2'd0;
      end else if (resp_failed_c) begin
         sticky_q <= 2'd2;
      end else if (busy_set_c) begin
         sticky_q <= 2'd3;
      end
   end

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         dmi_clear_o <= 1'b0;
      end else begin
         dmi_clear_o <= tlr_enter_c || hardreset_c;
      end
   end

   // DMI handshake: IDLE -> REQ -> WAIT_RESP -> IDLE, all outputs registered
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         dmi_state_q          <= DMI_IDLE;
         dmi.dmi_req_o        <= '0;
         dmi.dmi_req_valid_o  <= 1'b0;
         dmi.dmi_resp_ready_o <= 1'b0;
         last_addr_q          <= '0;
         last_data_q          <= '0;
      end else if (hardreset_c) begin
         dmi_state_q          <= DMI_IDLE;
         dmi.dmi_req_valid_o  <= 1'b0;
         dmi.dmi_resp_ready_o <= 1'b0;
      end else begin
         case (dmi_state_q)
            DMI_IDLE: begin
               if (start_c) begin
                  last_addr_q         <= upd_addr_c;
                  last_data_q         <= upd_data_c;
                  dmi.dmi_req_o       <= {upd_addr_c, dr_q[1:0], upd_data_c};
                  dmi.dmi_req_valid_o <= 1'b1;
                  dmi_state_q         <= DMI_REQ;
               end
            end
            DMI_REQ: begin
               if (dmi.dmi_req_ready_i) begin
                  dmi.dmi_req_valid_o  <= 1'b0;
                  dmi.dmi_resp_ready_o <= 1'b1;
                  dmi_state_q          <= DMI_WAIT_RESP;
               end
            end
            DMI_WAIT_RESP: begin
               if (dmi.dmi_resp_valid_i) begin
                  last_data_q          <= dmi.dmi_resp_i[RESP_W-1:2];
                  dmi.dmi_resp_ready_o <= 1'b0;
                  dmi_state_q          <= DMI_IDLE;
               end
            end
            default: dmi_state_q <= DMI_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmi_jtag_dtm_param.sv
// Directed bench for dmi_jtag_dtm_param: TAP/IR, IDCODE, DTMCS, DMI handshake and
// sticky error recovery, with expected values worked out by hand.
module tb_dmi_jtag_dtm_param;

   localparam int unsigned ABITS    = 7;
   localparam int unsigned IRLENGTH = 5;

   logic tck    = 1'b0;
   logic trst_n = 1'b0;
   logic tms    = 1'b1;
   logic tdi    = 1'b0;
   logic td_o;
   logic tdo_oe;
   logic dmi_clear;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic oe_bad  = 1'b0;

   dmi_jtag_dtm_param_if #(.ABITS(ABITS)) dmi_bus ();

   dmi_jtag_dtm_param #(
      .ABITS       (ABITS),
      .IRLENGTH    (IRLENGTH),
      .IDCODE      (32'h0000_0DB3),
      .IDLE_CYCLES (1)
   ) dut (
      .tck_i       (tck),
      .trst_ni     (trst_n),
      .tms_i       (tms),
      .td_i        (tdi),
      .td_o        (td_o),
      .tdo_oe_o    (tdo_oe),
      .dmi_clear_o (dmi_clear),
      .dmi         (dmi_bus)
   );

   always #5 tck = ~tck;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sample outputs just after the falling edge, then drive inputs for the next rising edge
   task automatic step(input logic tms_v, input logic tdi_v, output logic tdo_v, output logic oe_v);
      @(negedge tck);
      #1;
      tdo_v = td_o;
      oe_v  = tdo_oe;
      tms   = tms_v;
      tdi   = tdi_v;
   endtask

   // Full scan from Run-Test/Idle back to Run-Test/Idle
   task automatic scan(input logic is_ir, input logic [63:0] din, input int len, output logic [63:0] dout);
      logic t, o;
      dout = '0;
      step(1'b1, 1'b0, t, o); oe_bad |= o;
      if (is_ir) begin
         step(1'b1, 1'b0, t, o); oe_bad |= o;
      end
      step(1'b0, 1'b0, t, o); oe_bad |= o;
      step(1'b0, 1'b0, t, o); oe_bad |= o;
      for (int i = 0; i < len; i++) begin
         step(1'(i == len - 1), din[i], t, o);
         dout[i] = t;
         if (!o) oe_bad = 1'b1;
      end
      step(1'b1, 1'b0, t, o); oe_bad |= o;
      step(1'b0, 1'b0, t, o); oe_bad |= o;
   endtask

   task automatic set_ir(input logic [4:0] code);
      logic [63:0] d;
      scan(1'b1, 64'(code), IRLENGTH, d);
      check("ir_capture", d, 64'h05);
   endtask

   // Idle cycles while counting DMI-side activity
   task automatic watch(input int n, output int nv, output int nr, output int nc, output logic [63:0] req);
      logic t, o;
      nv = 0; nr = 0; nc = 0; req = '0;
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, t, o);
         if (dmi_bus.dmi_req_valid_o) begin
            nv++;
            req = 64'(dmi_bus.dmi_req_o);
         end
         if (dmi_bus.dmi_resp_ready_o) nr++;
         if (dmi_clear) nc++;
      end
   endtask

   function automatic logic [63:0] dmi_dr(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
      return 64'({a, d, op});
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] d, req;
      logic        t, o;
      int          nv, nr, nc;

      dmi_bus.dmi_req_ready_i  = 1'b0;
      dmi_bus.dmi_resp_i       = '0;
      dmi_bus.dmi_resp_valid_i = 1'b0;

      repeat (4) @(negedge tck);
      #1;
      check("rst_td_o",       64'(td_o), 64'h0);
      check("rst_tdo_oe",     64'(tdo_oe), 64'h0);
      check("rst_req_valid",  64'(dmi_bus.dmi_req_valid_o), 64'h0);
      check("rst_resp_ready", 64'(dmi_bus.dmi_resp_ready_o), 64'h0);
      check("rst_clear",      64'(dmi_clear), 64'h0);
      check("rst_req",        64'(dmi_bus.dmi_req_o), 64'h0);
      trst_n = 1'b1;
      step(1'b1, 1'b0, t, o);
      step(1'b0, 1'b0, t, o);

      // IDCODE selected straight out of reset, then explicitly
      scan(1'b0, 64'h0, 32, d);
      check("idcode_after_reset", d, 64'h0000_0DB3);
      set_ir(5'h01);
      scan(1'b0, 64'h0, 32, d);
      check("idcode", d, 64'h0000_0DB3);
      check("tdo_oe_shift_only", 64'(oe_bad), 64'h0);

      set_ir(5'h10);
      scan(1'b0, 64'h0, 32, d);
      check("dtmcs_clean", d, 64'h0000_1071);

      // Write 0x10 <- 1 with ready high, response success
      set_ir(5'h11);
      dmi_bus.dmi_req_ready_i  = 1'b1;
      dmi_bus.dmi_resp_i       = 34'h0;
      dmi_bus.dmi_resp_valid_i = 1'b1;
      scan(1'b0, dmi_dr(7'h10, 32'h1, 2'b10), 41, d);
      watch(6, nv, nr, nc, req);
      check("wr_valid_cycles", 64'(nv), 64'd1);
      check("wr_req_payload", req, 64'({7'h10, 2'b10, 32'h1}));
      check("wr_resp_ready_cycles", 64'(nr), 64'd1);
      dmi_bus.dmi_resp_valid_i = 1'b0;
      scan(1'b0, 64'h0, 41, d);
      check("dmi_status_ok", d, dmi_dr(7'h10, 32'h0, 2'b00));

      // Read 0x11 with response withheld; a second scan sees busy and is dropped
      scan(1'b0, dmi_dr(7'h11, 32'h0, 2'b01), 41, d);
      watch(4, nv, nr, nc, req);
      check("rd_valid_cycles", 64'(nv), 64'd1);
      check("rd_waiting_resp_ready", 64'(dmi_bus.dmi_resp_ready_o), 64'h1);
      scan(1'b0, dmi_dr(7'h12, 32'h0000_ABCD, 2'b10), 41, d);
      check("dmi_status_busy", d, dmi_dr(7'h11, 32'h0, 2'b11));
      watch(4, nv, nr, nc, req);
      check("busy_op_dropped", 64'(nv), 64'd0);
      set_ir(5'h10);
      scan(1'b0, 64'h0, 32, d);
      check("dtmcs_busy", d, 64'h0000_1C71);
      scan(1'b0, 64'h0001_0000, 32, d);
      check("dtmcs_busy_before_reset", d, 64'h0000_1C71);
      scan(1'b0, 64'h0, 32, d);
      check("dtmcs_after_dmireset", d, 64'h0000_1071);

      // Late failed response lands in last_data and sticky
      dmi_bus.dmi_resp_i       = {32'hDEAD_BEEF, 2'b10};
      dmi_bus.dmi_resp_valid_i = 1'b1;
      watch(3, nv, nr, nc, req);
      check("fail_resp_ready_dropped", 64'(dmi_bus.dmi_resp_ready_o), 64'h0);
      dmi_bus.dmi_resp_valid_i = 1'b0;
      set_ir(5'h11);
      scan(1'b0, 64'h0, 41, d);
      check("dmi_status_failed", d, dmi_dr(7'h11, 32'hDEAD_BEEF, 2'b10));

      // dmihardreset clears failed status and pulses dmi_clear
      set_ir(5'h10);
      scan(1'b0, 64'h0002_0000, 32, d);
      check("dtmcs_failed", d, 64'h0000_1871);
      watch(4, nv, nr, nc, req);
      check("hardreset_clear_pulse", 64'(nc), 64'd1);
      check("hardreset_no_valid", 64'(nv), 64'd0);
      scan(1'b0, 64'h0, 32, d);
      check("dtmcs_after_hardreset", d, 64'h0000_1071);

      // dmihardreset also drops an outstanding transaction
      set_ir(5'h11);
      scan(1'b0, dmi_dr(7'h05, 32'h5A5A_0000, 2'b01), 41, d);
      check("dmi_cap_after_hardreset", d, dmi_dr(7'h11, 32'hDEAD_BEEF, 2'b00));
      watch(3, nv, nr, nc, req);
      check("drop_waiting", 64'(dmi_bus.dmi_resp_ready_o), 64'h1);
      set_ir(5'h10);
      scan(1'b0, 64'h0002_0000, 32, d);
      check("dtmcs_outstanding_no_busy", d, 64'h0000_1071);
      watch(3, nv, nr, nc, req);
      check("drop_clear_pulse", 64'(nc), 64'd1);
      check("drop_resp_ready", 64'(dmi_bus.dmi_resp_ready_o), 64'h0);
      set_ir(5'h11);
      scan(1'b0, 64'h0, 41, d);
      check("dmi_after_drop", d, dmi_dr(7'h05, 32'h5A5A_0000, 2'b00));

      // Five TMS=1 cycles: one dmi_clear pulse, IR back to IDCODE
      nc = 0;
      for (int k = 0; k < 8; k++) begin
         step(1'(k < 5), 1'b0, t, o);
         if (dmi_clear) nc++;
      end
      check("tlr_clear_pulse", 64'(nc), 64'd1);
      scan(1'b0, 64'h0, 32, d);
      check("idcode_after_tlr", d, 64'h0000_0DB3);

`ifdef DTM_BUSY_COUNT_EN
      set_ir(5'h12);
      scan(1'b0, 64'h0, 16, d);
      check("busycnt_one", d, 64'd1);
      scan(1'b0, 64'h1, 16, d);
      check("busycnt_before_clear", d, 64'd1);
      scan(1'b0, 64'h0, 16, d);
      check("busycnt_cleared", d, 64'd0);
`else
      set_ir(5'h12);
      scan(1'b0, 64'b101101, 6, d);
      check("ir12_bypass", d, 64'b011010);
`endif
      set_ir(5'h03);
      scan(1'b0, 64'b110011, 6, d);
      check("unknown_ir_bypass", d, 64'b100110);
      set_ir(5'h1F);
      scan(1'b0, 64'b000111, 6, d);
      check("bypass", d, 64'b001110);
      check("tdo_oe_final", 64'(oe_bad), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
